branch_resolve_queue: RTL and testbench

In-order queue of fetch-time branch predictions between IF and EX. IF pushes one record per fetched instruction: PC, BTB hit, BTB target. EX retires records in program order with the resolved outcome. The block detects next-PC mispredictions, issues a one-cycle flush with the correct redirect PC, and generates the BTB training write.

---
 rtl/branch_resolve_queue.sv | 126 ++++++++++++
 tb/tb_branch_resolve_queue.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_queue.sv
// In-order queue of fetch-time branch predictions; resolves them in program order, flags next-PC mispredicts, trains the BTB.
// flush/redirect/BTB write appear 1 cycle after resolve; enq_ready drops while full or flushing (no same-cycle bypass).
module branch_resolve_queue #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   enq_valid,
   input  logic [XLEN-1:0]        enq_pc,
   input  logic                   enq_pred_taken,
   input  logic [XLEN-1:0]        enq_pred_target,
   output logic                   enq_ready,
   input  logic                   res_valid,
   input  logic                   res_is_branch_or_jump,
   input  logic                   res_taken,
   input  logic [XLEN-1:0]        res_target,
   output logic                   flush,
   output logic [XLEN-1:0]        redirect_pc,
   output logic                   btb_update_enable,
   output logic [XLEN-1:0]        btb_pc_update,
   output logic [XLEN-1:0]        btb_target_update,
   output logic                   btb_is_branch_or_jump,
   output logic [$clog2(DEPTH):0] count,
   output logic                   res_underflow
);
   localparam int AW = $clog2(DEPTH);
   typedef logic [AW:0] ptr_t;

   logic [XLEN-1:0] pc_q  [DEPTH];
   logic [XLEN-1:0] tgt_q [DEPTH];
   logic [DEPTH-1:0] hit_q;

   ptr_t wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic flush_q, flush_d;
   logic [XLEN-1:0] redirect_q, redirect_d;
   logic btb_en_q, btb_en_d;
   logic [XLEN-1:0] btb_pc_q, btb_pc_d, btb_tgt_q, btb_tgt_d;
   logic underflow_q, underflow_d;

   logic empty, full, enq_fire, res_fire, act_taken, mispredict;
   logic [AW-1:0] head_idx, tail_idx;
   logic [XLEN-1:0] seq_pc, pred_next, act_next;

   assign empty     = (wr_ptr_q == rd_ptr_q);
   assign full      = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
   assign enq_ready = !full && !flush_q;
   assign enq_fire  = enq_valid && enq_ready;
   assign res_fire  = res_valid && !empty && !flush_q;
   assign head_idx  = rd_ptr_q[AW-1:0];
   assign tail_idx  = wr_ptr_q[AW-1:0];

   // Non-branches never transfer control, whatever EX reports on res_taken.
   assign act_taken  = res_taken && res_is_branch_or_jump;
   assign seq_pc     = pc_q[head_idx] + XLEN'(4);
   assign pred_next  = hit_q[head_idx] ? tgt_q[head_idx] : seq_pc;
   assign act_next   = act_taken ? res_target : seq_pc;
   assign mispredict = res_fire && (pred_next != act_next);

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      flush_d     = 1'b0;
      redirect_d  = redirect_q;
      btb_en_d    = 1'b0;
      btb_pc_d    = btb_pc_q;
      btb_tgt_d   = btb_tgt_q;
      underflow_d = res_valid && empty && !flush_q;
      if (mispredict) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         flush_d    = 1'b1;
         redirect_d = act_next;
      end else begin
         wr_ptr_d = wr_ptr_q + ptr_t'(enq_fire);
         rd_ptr_d = rd_ptr_q + ptr_t'(res_fire);
      end
      if (res_fire && act_taken) begin
         btb_en_d  = 1'b1;
         btb_pc_d  = pc_q[head_idx];
         btb_tgt_d = res_target;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         flush_q     <= 1'b0;
         redirect_q  <= '0;
         btb_en_q    <= 1'b0;
         btb_pc_q    <= '0;
         btb_tgt_q   <= '0;
         underflow_q <= 1'b0;
         hit_q       <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_q[i]  <= '0;
            tgt_q[i] <= '0;
         end
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         flush_q     <= flush_d;
         redirect_q  <= redirect_d;
         btb_en_q    <= btb_en_d;
         btb_pc_q    <= btb_pc_d;
         btb_tgt_q   <= btb_tgt_d;
         underflow_q <= underflow_d;
         // A record fetched alongside a mispredict is on the wrong path.
         if (enq_fire && !mispredict) begin
            pc_q[tail_idx]  <= enq_pc;
            tgt_q[tail_idx] <= enq_pred_target;
            hit_q[tail_idx] <= enq_pred_taken;
         end
      end
   end

   assign flush                 = flush_q;
   assign redirect_pc           = redirect_q;
   assign btb_update_enable     = btb_en_q;
   assign btb_pc_update         = btb_pc_q;
   assign btb_target_update     = btb_tgt_q;
   assign btb_is_branch_or_jump = btb_en_q;
   assign count                 = wr_ptr_q - rd_ptr_q;
   assign res_underflow         = underflow_q;
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue: hand-computed expectations for fill, predict, mispredict, boundary and wrap cases.
module tb_branch_resolve_queue;
   logic        clk = 1'b0;
   logic        reset_n;
   logic        enq_valid, enq_pred_taken, enq_ready;
   logic [31:0] enq_pc, enq_pred_target;
   logic        res_valid, res_is_branch_or_jump, res_taken;
   logic [31:0] res_target;
   logic        flush, btb_update_enable, btb_is_branch_or_jump, res_underflow;
   logic [31:0] redirect_pc, btb_pc_update, btb_target_update;
   logic [2:0]  count;

   int n_cmp = 0;
   int n_err = 0;

   branch_resolve_queue #(.DEPTH(4), .XLEN(32)) dut (
      .clk(clk), .reset_n(reset_n),
      .enq_valid(enq_valid), .enq_pc(enq_pc), .enq_pred_taken(enq_pred_taken),
      .enq_pred_target(enq_pred_target), .enq_ready(enq_ready),
      .res_valid(res_valid), .res_is_branch_or_jump(res_is_branch_or_jump),
      .res_taken(res_taken), .res_target(res_target),
      .flush(flush), .redirect_pc(redirect_pc),
      .btb_update_enable(btb_update_enable), .btb_pc_update(btb_pc_update),
      .btb_target_update(btb_target_update), .btb_is_branch_or_jump(btb_is_branch_or_jump),
      .count(count), .res_underflow(res_underflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      enq_valid = 1'b0;
      res_valid = 1'b0;
      res_is_branch_or_jump = 1'b0;
      res_taken = 1'b0;
   endtask

   task automatic set_enq(input logic [31:0] pc, input logic hit, input logic [31:0] tgt);
      enq_valid = 1'b1;
      enq_pc = pc;
      enq_pred_taken = hit;
      enq_pred_target = tgt;
   endtask

   task automatic set_res(input logic br, input logic tk, input logic [31:0] tgt);
      res_valid = 1'b1;
      res_is_branch_or_jump = br;
      res_taken = tk;
      res_target = tgt;
   endtask

   task automatic enq(input logic [31:0] pc, input logic hit, input logic [31:0] tgt);
      set_enq(pc, hit, tgt);
      tick();
      clr();
   endtask

   task automatic res(input logic br, input logic tk, input logic [31:0] tgt);
      set_res(br, tk, tgt);
      tick();
      clr();
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, ".flush"}, flush, 0);
      check({tag, ".redirect"}, redirect_pc, 0);
      check({tag, ".btb_en"}, btb_update_enable, 0);
      check({tag, ".btb_pc"}, btb_pc_update, 0);
      check({tag, ".btb_tgt"}, btb_target_update, 0);
      check({tag, ".btb_ibj"}, btb_is_branch_or_jump, 0);
      check({tag, ".count"}, count, 0);
      check({tag, ".underflow"}, res_underflow, 0);
      check({tag, ".enq_ready"}, enq_ready, 1);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      reset_n = 1'b0;
      enq_pc = '0; enq_pred_taken = 1'b0; enq_pred_target = '0; res_target = '0;
      clr();
      #1;
      check_reset_state("rst");
      #11 reset_n = 1'b1;

      // Fill to DEPTH with sequential non-hit records.
      enq(32'h00, 0, 0);
      enq(32'h04, 0, 0);
      enq(32'h08, 0, 0);
      enq(32'h0C, 0, 0);
      check("fill.count", count, 4);
      check("fill.enq_ready", enq_ready, 0);
      enq(32'h10, 0, 0);
      check("fill.5th_dropped", count, 4);
      for (int i = 0; i < 4; i++) begin
         res(0, 0, 0);
         check("drain.flush", flush, 0);
         check("drain.btb_en", btb_update_enable, 0);
      end
      check("drain.count", count, 0);

      // Correctly predicted taken branch trains BTB without flush.
      enq(32'h100, 1, 32'h200);
      res(1, 1, 32'h200);
      check("hit.flush", flush, 0);
      check("hit.btb_en", btb_update_enable, 1);
      check("hit.btb_ibj", btb_is_branch_or_jump, 1);
      check("hit.btb_pc", btb_pc_update, 32'h100);
      check("hit.btb_tgt", btb_target_update, 32'h200);
      tick();
      check("hit.btb_pulse", btb_update_enable, 0);

      // Missed taken branch, with a wrong-path enqueue in the resolving cycle.
      enq(32'h40, 0, 0);
      enq(32'h44, 0, 0);
      enq(32'h48, 0, 0);
      check("miss.count_pre", count, 3);
      set_res(1, 1, 32'h80);
      set_enq(32'h4C, 0, 0);
      tick();
      check("miss.flush", flush, 1);
      check("miss.redirect", redirect_pc, 32'h80);
      check("miss.btb_en", btb_update_enable, 1);
      check("miss.btb_pc", btb_pc_update, 32'h40);
      check("miss.btb_tgt", btb_target_update, 32'h80);
      check("miss.count", count, 0);
      check("miss.enq_ready_flush", enq_ready, 0);
      // Inputs during the flush cycle must be ignored.
      set_res(1, 1, 32'h99);
      tick();
      clr();
      check("miss.flush_fall", flush, 0);
      check("miss.count_after", count, 0);
      check("miss.enq_ready_after", enq_ready, 1);
      check("miss.btb_ignored", btb_update_enable, 0);
      check("miss.no_underflow", res_underflow, 0);

      // False hit resolved not-taken.
      enq(32'h10, 1, 32'h50);
      res(1, 0, 0);
      check("false.flush", flush, 1);
      check("false.redirect", redirect_pc, 32'h14);
      check("false.btb_en", btb_update_enable, 0);
      tick();
      check("false.flush_fall", flush, 0);

      // Address wrap: 0xFFFFFFFC + 4 = 0.
      enq(32'hFFFF_FFFC, 1, 32'h0);
      res(1, 0, 0);
      check("wrap4.hit_nt_flush", flush, 0);
      check("wrap4.hit_nt_btb", btb_update_enable, 0);
      enq(32'hFFFF_FFFC, 0, 0);
      res(1, 1, 32'h0);
      check("wrap4.nohit_t_flush", flush, 0);
      check("wrap4.nohit_t_btb", btb_update_enable, 1);
      check("wrap4.btb_pc", btb_pc_update, 32'hFFFF_FFFC);
      check("wrap4.btb_tgt", btb_target_update, 32'h0);
      // res_taken on a non-branch is not a transfer.
      enq(32'h20, 0, 0);
      res(0, 1, 32'h999);
      check("nonbr_taken.flush", flush, 0);
      check("nonbr_taken.btb", btb_update_enable, 0);

      // Underflow cases.
      res(0, 0, 0);
      check("uf.pulse", res_underflow, 1);
      check("uf.count", count, 0);
      tick();
      check("uf.fall", res_underflow, 0);
      set_enq(32'h60, 0, 0);
      set_res(0, 0, 0);
      tick();
      clr();
      check("uf_enq.count", count, 1);
      check("uf_enq.pulse", res_underflow, 1);
      res(0, 0, 0);
      check("uf_enq.drain", count, 0);

      // Simultaneous enq/res at count=2.
      enq(32'h70, 0, 0);
      enq(32'h74, 0, 0);
      set_enq(32'h78, 0, 0);
      set_res(0, 0, 0);
      tick();
      clr();
      check("both.count", count, 2);
      check("both.flush", flush, 0);
      res(0, 0, 0);
      res(0, 0, 0);
      check("both.drain", count, 0);

      // Pointer wrap: each head resolves taken to its own predicted target, so any corruption flushes.
      enq(32'h1000, 1, 32'h2000);
      for (int i = 0; i < 10; i++) begin
         set_enq(32'h1000 + (i + 1) * 16, 1, 32'h2000 + (i + 1) * 8);
         set_res(1, 1, 32'h2000 + i * 8);
         tick();
         clr();
         check("ring.flush", flush, 0);
         check("ring.btb_pc", btb_pc_update, 32'h1000 + i * 16);
         check("ring.count", count, 1);
      end
      res(1, 1, 32'h2000 + 10 * 8);
      check("ring.last_pc", btb_pc_update, 32'h1000 + 10 * 16);
      check("ring.last_flush", flush, 0);
      check("ring.drain", count, 0);

      // Asynchronous reset with count=3 and a mispredict being resolved.
      enq(32'h300, 0, 0);
      enq(32'h304, 0, 0);
      enq(32'h308, 0, 0);
      check("arst.count_pre", count, 3);
      set_res(1, 1, 32'h500);
      #2 reset_n = 1'b0;
      #1;
      check_reset_state("arst");
      clr();
      tick();
      check("arst.held_flush", flush, 0);
      #2 reset_n = 1'b1;
      enq(32'h400, 0, 0);
      check("post.count", count, 1);
      res(0, 0, 0);
      check("post.drain", count, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
